// File: rtl/timer_countdown_pkg.sv
// rtl/timer_countdown_pkg.sv - shared state constants and width helper for the countdown timer
package timer_countdown_pkg;

  // FSM state type and encodings
  typedef logic [1:0] timer_state_t;

  localparam timer_state_t ST_IDLE = 2'd0;
  localparam timer_state_t ST_RUN  = 2'd1;
  localparam timer_state_t ST_DONE = 2'd2;

  // Number of bits needed to hold 0..max_value (never less than one bit)
  function automatic int tc_width(input int max_value);
    return (max_value < 1) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/timer_countdown_if.sv
// rtl/timer_countdown_if.sv - control and status bundle of the countdown timer
interface timer_countdown_if #(
  parameter int W = 8
);
  logic         enable;
  logic         load;
  logic [W-1:0] load_value;
  logic         start;
  logic         stop;
  logic         auto_reload;
  logic [W-1:0] count;
  logic         running;
  logic         expired;

  // Controller side: drives commands, observes status
  modport master (
    output enable, load, load_value, start, stop, auto_reload,
    input  count, running, expired
  );

  // Timer side: consumes commands, reports status
  modport slave (
    input  enable, load, load_value, start, stop, auto_reload,
    output count, running, expired
  );
endinterface

// File: rtl/counter_binary.sv
// rtl/counter_binary.sv - wrapping up-counter 0..MAX_VALUE with synchronous clear
module counter_binary
  import timer_countdown_pkg::*;
#(
  parameter int MAX_VALUE = 3,
  parameter int W         = tc_width(MAX_VALUE)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  localparam logic [W-1:0] TOP = W'(MAX_VALUE);

  logic [W-1:0] count_q, count_d;

  // Clear dominates; otherwise advance and wrap back to zero after TOP
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = (count_q == TOP) ? '0 : count_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/decrementer.sv
// rtl/decrementer.sv - combinational subtract of a fixed step, saturating at zero
module decrementer
  import timer_countdown_pkg::*;
#(
  parameter int MAX_VALUE = 255,
  parameter int DECREMENT = 1,
  parameter int W         = tc_width(MAX_VALUE)
) (
  input  logic [W-1:0] data_in,
  output logic [W-1:0] data_out
);

  localparam logic [W-1:0] STEP = W'(DECREMENT);

  // Anything at or below one step lands on zero instead of wrapping
  assign data_out = (data_in > STEP) ? data_in - STEP : '0;

endmodule

// File: rtl/timer_countdown.sv
// rtl/timer_countdown.sv - loadable prescaled down-counting timer with one-shot/periodic expiry
module timer_countdown
  import timer_countdown_pkg::*;
#(
  parameter int MAX_VALUE = 255,
  parameter int DECREMENT = 1,
  parameter int PRESCALE  = 1
) (
  input  logic              clk,
  input  logic              reset,
  timer_countdown_if.slave  bus
);

  localparam int           W     = tc_width(MAX_VALUE);
  localparam logic [W-1:0] MAX_V = W'(MAX_VALUE);

  timer_state_t state_q, state_d;
  logic [W-1:0] count_q, count_d;
  logic [W-1:0] reload_q, reload_d;
  logic         expired_q, expired_d;
  logic         running_q;

  logic [W-1:0] load_clamped;
  logic [W-1:0] dec_out;
  logic         in_run;
  logic         start_ok;
  logic         presc_inc;
  logic         presc_at_end;
  logic         tick;

  assign load_clamped = (bus.load_value > MAX_V) ? MAX_V : bus.load_value;
  assign in_run       = (state_q == ST_RUN);

  // A start is honoured only outside RUN and only when no stop competes with it
  assign start_ok  = bus.start && !bus.stop && !in_run;

  // Prescaler advances on enabled RUN cycles not pre-empted by load or stop
  assign presc_inc = in_run && bus.enable && !bus.load && !bus.stop;
  assign tick      = presc_inc && presc_at_end;

  generate
    if (PRESCALE > 1) begin : g_presc
      localparam int PW = tc_width(PRESCALE - 1);
      logic [PW-1:0] presc_count;
      logic          presc_clear;

      // Restart the tick phase whenever a new value is loaded or a run begins
      assign presc_clear  = bus.load || start_ok;
      assign presc_at_end = (presc_count == PW'(PRESCALE - 1));

      counter_binary #(
        .MAX_VALUE (PRESCALE - 1)
      ) u_presc (
        .clk     (clk),
        .reset   (reset),
        .clear_i (presc_clear),
        .inc_i   (presc_inc),
        .count_o (presc_count)
      );
    end else begin : g_no_presc
      assign presc_at_end = 1'b1;
    end
  endgenerate

  decrementer #(
    .MAX_VALUE (MAX_VALUE),
    .DECREMENT (DECREMENT)
  ) u_dec (
    .data_in  (count_q),
    .data_out (dec_out)
  );

  // Next-state logic, priority load > stop > start > tick
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    expired_d = 1'b0;

    if (bus.load) begin
      count_d  = load_clamped;
      reload_d = load_clamped;
      if (start_ok) begin
        if (load_clamped == '0) begin
          state_d   = ST_DONE;
          expired_d = 1'b1;
        end else begin
          state_d   = ST_RUN;
        end
      end else if (state_q == ST_DONE) begin
        state_d = ST_IDLE;
      end
    end else if (bus.stop) begin
      if (in_run) begin
        state_d = ST_IDLE;
      end
    end else if (start_ok) begin
      if (count_q == '0) begin
        state_d   = ST_DONE;
        expired_d = 1'b1;
      end else begin
        state_d   = ST_RUN;
      end
    end else if (tick) begin
      if (dec_out == '0) begin
        expired_d = 1'b1;
        if (bus.auto_reload && (reload_q != '0)) begin
          // Periodic mode jumps straight back to the reload value; zero is never shown
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = ST_DONE;
        end
      end else begin
        count_d = dec_out;
      end
    end
  end

  // State, count and registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      expired_q <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      expired_q <= expired_d;
      running_q <= (state_d == ST_RUN);
    end
  end

  assign bus.count   = count_q;
  assign bus.running = running_q;
  assign bus.expired = expired_q;

endmodule

// File: tb/tb_timer_countdown.sv
// tb/tb_timer_countdown.sv - randomized and directed bench for timer_countdown against a behavioural model
module tb_timer_countdown;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_value = 8'd0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       auto_reload = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  timer_countdown_if #(.W(8)) if0 ();
  timer_countdown_if #(.W(8)) if1 ();
  timer_countdown_if #(.W(8)) if2 ();

  assign if0.enable = enable; assign if0.load = load; assign if0.load_value = load_value;
  assign if0.start = start; assign if0.stop = stop; assign if0.auto_reload = auto_reload;
  assign if1.enable = enable; assign if1.load = load; assign if1.load_value = load_value;
  assign if1.start = start; assign if1.stop = stop; assign if1.auto_reload = auto_reload;
  assign if2.enable = enable; assign if2.load = load; assign if2.load_value = load_value;
  assign if2.start = start; assign if2.stop = stop; assign if2.auto_reload = auto_reload;

  timer_countdown #(.MAX_VALUE(255), .DECREMENT(1), .PRESCALE(1)) u0 (.clk(clk), .reset(reset), .bus(if0));
  timer_countdown #(.MAX_VALUE(255), .DECREMENT(1), .PRESCALE(4)) u1 (.clk(clk), .reset(reset), .bus(if1));
  timer_countdown #(.MAX_VALUE(200), .DECREMENT(2), .PRESCALE(1)) u2 (.clk(clk), .reset(reset), .bus(if2));

  int d_cnt [3];
  int d_run [3];
  int d_exp [3];
  assign d_cnt[0] = int'(if0.count); assign d_run[0] = int'(if0.running); assign d_exp[0] = int'(if0.expired);
  assign d_cnt[1] = int'(if1.count); assign d_run[1] = int'(if1.running); assign d_exp[1] = int'(if1.expired);
  assign d_cnt[2] = int'(if2.count); assign d_run[2] = int'(if2.running); assign d_exp[2] = int'(if2.expired);

  // Model: per instance, counting flag + finished flag + enabled cycles since last tick
  int cfg_max [3] = '{255, 255, 200};
  int cfg_dec [3] = '{1, 1, 2};
  int cfg_pre [3] = '{1, 4, 1};
  int m_cnt  [3] = '{0, 0, 0};
  int m_rel  [3] = '{0, 0, 0};
  int m_pre  [3] = '{0, 0, 0};
  int m_run  [3] = '{0, 0, 0};
  int m_done [3] = '{0, 0, 0};
  int m_exp  [3] = '{0, 0, 0};

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_rel[i] = 0; m_pre[i] = 0;
      m_run[i] = 0; m_done[i] = 0; m_exp[i] = 0;
    end
  endtask

  task automatic begin_run(input int i, input int value);
    m_pre[i] = 0;
    if (value == 0) begin
      m_run[i] = 0; m_done[i] = 1; m_exp[i] = 1;
    end else begin
      m_run[i] = 1; m_done[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    int v;
    bit go;
    m_exp[i] = 0;
    go = start && !stop && (m_run[i] == 0);
    if (load) begin
      v = (int'(load_value) > cfg_max[i]) ? cfg_max[i] : int'(load_value);
      m_cnt[i] = v; m_rel[i] = v; m_pre[i] = 0;
      if (go) begin_run(i, v);
      else if (m_done[i] != 0) m_done[i] = 0;
    end else if (stop) begin
      m_run[i] = 0;
    end else if (go) begin
      begin_run(i, m_cnt[i]);
    end else if (m_run[i] != 0 && enable) begin
      m_pre[i] = m_pre[i] + 1;
      if (m_pre[i] == cfg_pre[i]) begin
        m_pre[i] = 0;
        v = m_cnt[i] - cfg_dec[i];
        if (v < 0) v = 0;
        if (v == 0) begin
          m_exp[i] = 1;
          if (auto_reload && m_rel[i] != 0) m_cnt[i] = m_rel[i];
          else begin m_cnt[i] = 0; m_run[i] = 0; m_done[i] = 1; end
        end else begin
          m_cnt[i] = v;
        end
      end
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else for (int i = 0; i < 3; i++) model_step(i);
  end

  // Every cycle, away from the active edge, all outputs must match the model
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model_count_u%0d", i), d_cnt[i], m_cnt[i]);
      chk($sformatf("model_running_u%0d", i), d_run[i], m_run[i]);
      chk($sformatf("model_expired_u%0d", i), d_exp[i], m_exp[i]);
    end
  end

  task automatic clr();
    load = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  int exp_at;
  int r;

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Run, then async reset mid-cycle with count=7
    @(negedge clk); load = 1'b1; load_value = 8'd9;
    @(negedge clk); load = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_count", d_cnt[0], 7);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_count", d_cnt[0], 0);
    chk("async_reset_running", d_run[0], 0);
    chk("async_reset_expired", d_exp[0], 0);
    chk("async_reset_count_u1", d_cnt[1], 0);

    // One-shot from 5
    @(negedge clk); reset = 1'b1; load = 1'b1; load_value = 8'd5;
    @(negedge clk); load = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("oneshot_start_count", d_cnt[0], 5);
    chk("oneshot_start_running", d_run[0], 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("oneshot_count", d_cnt[0], 4 - i);
      chk("oneshot_expired", d_exp[0], (i == 4) ? 1 : 0);
    end
    chk("oneshot_done_running", d_run[0], 0);
    @(negedge clk);
    chk("oneshot_after_expired", d_exp[0], 0);

    // Prescale 4 with a two-cycle enable stall
    stop = 1'b1;
    @(negedge clk); stop = 1'b0; load = 1'b1; load_value = 8'd3; start = 1'b1;
    @(negedge clk); clr();
    exp_at = -1;
    for (int k = 1; k <= 16; k++) begin
      enable = !(k == 5 || k == 6);
      @(negedge clk);
      if (k == 4) chk("presc_first_tick", d_cnt[1], 2);
      if (d_exp[1] != 0 && exp_at < 0) exp_at = k;
    end
    enable = 1'b1;
    chk("presc_expiry_cycle", exp_at, 14);

    // Auto-reload with DECREMENT=2: 3,1,3,1 and never zero
    auto_reload = 1'b1; load = 1'b1; load_value = 8'd3; start = 1'b1;
    @(negedge clk); clr();
    chk("reload_start_count", d_cnt[2], 3);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("reload_count", d_cnt[2], (k % 2 == 1) ? 1 : 3);
      chk("reload_expired", d_exp[2], (k % 2 == 0) ? 1 : 0);
    end

    // load beats stop in RUN; stop beats start
    load = 1'b1; load_value = 8'd9; stop = 1'b1;
    @(negedge clk); clr();
    chk("load_over_stop_count", d_cnt[0], 9);
    chk("load_over_stop_running", d_run[0], 1);
    stop = 1'b1; start = 1'b1;
    @(negedge clk); clr();
    chk("stop_over_start_count", d_cnt[0], 9);
    chk("stop_over_start_running", d_run[0], 0);

    // Clamp and zero start
    load = 1'b1; load_value = 8'd250;
    @(negedge clk);
    chk("noclamp_u0", d_cnt[0], 250);
    chk("clamp_u2", d_cnt[2], 200);
    load_value = 8'd0;
    @(negedge clk); load = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("zero_start_expired", d_exp[0], 1);
    chk("zero_start_running", d_run[0], 0);
    chk("zero_start_count", d_cnt[0], 0);
    @(negedge clk);
    chk("zero_start_single_pulse", d_exp[0], 0);

    // Reload value forced to zero mid-run: expiry ends in DONE, no re-pulse
    auto_reload = 1'b1; load = 1'b1; load_value = 8'd4; start = 1'b1;
    @(negedge clk); clr();
    @(negedge clk); load = 1'b1; load_value = 8'd0;
    @(negedge clk); load = 1'b0;
    chk("rz_loaded_count", d_cnt[0], 0);
    chk("rz_loaded_running", d_run[0], 1);
    @(negedge clk);
    chk("rz_expired", d_exp[0], 1);
    chk("rz_done_running", d_run[0], 0);
    repeat (3) begin
      @(negedge clk);
      chk("rz_no_repulse", d_exp[0], 0);
    end

    // Randomized traffic, including occasional asynchronous resets
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      r = $urandom_range(0, 99);
      load = (r < 4);
      load_value = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
      start = ($urandom_range(0, 99) < 12);
      stop = ($urandom_range(0, 99) < 3);
      enable = ($urandom_range(0, 99) < 85);
      auto_reload = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 399) == 0) begin
        #2 reset = 1'b0;
        #1 reset = 1'b1;
      end
    end
    clr();
    @(negedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
